// File: rtl/ifu_fetch_queue.sv
// Instruction-fetch front end: sequential fetch with bounded outstanding requests, an in-order
// instruction queue toward EXU, flush redirect with stale-response dropping, and halt handshake.
module ifu_fetch_queue #(
  parameter int unsigned PC_W    = 32,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MAX_OTF = 2,
  localparam int unsigned OtfW   = $clog2(MAX_OTF + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PC_W-1:0]    pc_rtvec,
  output logic               ifu_req_valid,
  input  logic               ifu_req_ready,
  output logic [PC_W-1:0]    ifu_req_pc,
  input  logic               ifu_rsp_valid,
  output logic               ifu_rsp_ready,
  input  logic               ifu_rsp_err,
  input  logic [INSTR_W-1:0] ifu_rsp_instr,
  output logic               ifu_o_valid,
  input  logic               ifu_o_ready,
  output logic [INSTR_W-1:0] ifu_o_ir,
  output logic [PC_W-1:0]    ifu_o_pc,
  output logic               ifu_o_buserr,
  input  logic               pipe_flush_req,
  input  logic [PC_W-1:0]    pipe_flush_pc,
  output logic               pipe_flush_ack,
  input  logic               ifu_halt_req,
  output logic               ifu_halt_ack,
  output logic [OtfW-1:0]    ifu_otf_cnt
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic               run_q;
  logic               start_pend_q, start_pend_d;
  logic               flushed_q, flushed_d;
  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]    rsp_pc_q, rsp_pc_d;
  logic [OtfW-1:0]    otf_cnt_q, otf_cnt_d;
  logic [OtfW-1:0]    drop_cnt_q, drop_cnt_d;
  logic               halt_ack_q, halt_ack_d;
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [INSTR_W-1:0] ir_q [DEPTH];
  logic [PC_W-1:0]    pc_q [DEPTH];
  logic [DEPTH-1:0]   err_q;

  logic req_hs, rsp_hs, push, pop;
  logic [31:0] otf_ext, cnt_ext;

  assign otf_ext = 32'(otf_cnt_q);
  assign cnt_ext = 32'(cnt_q);

  // Credit check counts outstanding requests against free queue entries, so a response
  // always has somewhere to land and the response channel never stalls.
  assign ifu_req_valid = run_q & ~pipe_flush_req & ~ifu_halt_req & ~halt_ack_q &
                         (otf_ext < MAX_OTF) & ((otf_ext + cnt_ext) < DEPTH);
  assign ifu_req_pc    = (start_pend_q & ~flushed_q) ? pc_rtvec : fetch_pc_q;
  assign ifu_rsp_ready = 1'b1;
  assign pipe_flush_ack = 1'b1;

  assign req_hs = ifu_req_valid & ifu_req_ready;
  assign rsp_hs = ifu_rsp_valid;
  assign push   = rsp_hs & ~pipe_flush_req & (drop_cnt_q == '0);
  assign pop    = ifu_o_valid & ifu_o_ready;

  assign ifu_o_valid  = (cnt_q != '0) & ~pipe_flush_req;
  assign ifu_o_ir     = ir_q[rd_ptr_q];
  assign ifu_o_pc     = pc_q[rd_ptr_q];
  assign ifu_o_buserr = err_q[rd_ptr_q];
  assign ifu_halt_ack = halt_ack_q;
  assign ifu_otf_cnt  = otf_cnt_q;

  always_comb begin
    start_pend_d = start_pend_q;
    flushed_d    = flushed_q | pipe_flush_req;
    fetch_pc_d   = fetch_pc_q;
    rsp_pc_d     = rsp_pc_q;
    otf_cnt_d    = otf_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    halt_ack_d   = halt_ack_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;

    if (req_hs && !rsp_hs) begin
      otf_cnt_d = otf_cnt_q + OtfW'(1);
    end else if (!req_hs && rsp_hs) begin
      otf_cnt_d = otf_cnt_q - OtfW'(1);
    end

    if (push) begin
      rsp_pc_d = rsp_pc_q + PC_W'(4);
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (push && !pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (!push && pop) begin
      cnt_d = cnt_q - CntW'(1);
    end

    if (req_hs) begin
      fetch_pc_d = ifu_req_pc + PC_W'(4);
      if (start_pend_q) begin
        rsp_pc_d     = ifu_req_pc;
        start_pend_d = 1'b0;
      end
    end

    if (pipe_flush_req) begin
      fetch_pc_d   = pipe_flush_pc;
      start_pend_d = 1'b1;
      drop_cnt_d   = otf_cnt_q - OtfW'(rsp_hs);
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      cnt_d        = '0;
    end else if (rsp_hs && drop_cnt_q != '0) begin
      drop_cnt_d = drop_cnt_q - OtfW'(1);
    end

    if (!ifu_halt_req) begin
      halt_ack_d = 1'b0;
    end else if (otf_cnt_q == '0) begin
      halt_ack_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q        <= 1'b0;
      start_pend_q <= 1'b1;
      flushed_q    <= 1'b0;
      fetch_pc_q   <= '0;
      rsp_pc_q     <= '0;
      otf_cnt_q    <= '0;
      drop_cnt_q   <= '0;
      halt_ack_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
    end else begin
      run_q        <= 1'b1;
      start_pend_q <= start_pend_d;
      flushed_q    <= flushed_d;
      fetch_pc_q   <= fetch_pc_d;
      rsp_pc_q     <= rsp_pc_d;
      otf_cnt_q    <= otf_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      halt_ack_q   <= halt_ack_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ir_q[i] <= '0;
        pc_q[i] <= '0;
      end
      err_q <= '0;
    end else if (push) begin
      ir_q[wr_ptr_q]  <= ifu_rsp_instr;
      pc_q[wr_ptr_q]  <= rsp_pc_q;
      err_q[wr_ptr_q] <= ifu_rsp_err;
    end
  end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed bench for ifu_fetch_queue: boot, backpressure, flushes, halt, reset, and an
// 8-bit-PC instance for bus-error delivery and PC wraparound.
module tb_ifu_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_rtvec;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_req_pc;
  logic        ifu_rsp_valid, ifu_rsp_ready, ifu_rsp_err;
  logic [31:0] ifu_rsp_instr;
  logic        ifu_o_valid, ifu_o_ready;
  logic [31:0] ifu_o_ir, ifu_o_pc;
  logic        ifu_o_buserr;
  logic        pipe_flush_req;
  logic [31:0] pipe_flush_pc;
  logic        pipe_flush_ack;
  logic        ifu_halt_req, ifu_halt_ack;
  logic [1:0]  ifu_otf_cnt;

  logic        rst_s_n;
  logic        req_valid_s, rsp_valid_s, rsp_ready_s, rsp_err_s, o_valid_s, o_buserr_s;
  logic        flush_ack_s, halt_ack_s;
  logic [7:0]  req_pc_s, o_pc_s;
  logic [31:0] rsp_instr_s, o_ir_s;
  logic [1:0]  otf_cnt_s;

  int          n_checks, n_errors;
  int          n_pop, n_req, base;
  logic [31:0] exp_pc, last_req_pc;
  logic [31:0] bus_q[$];
  bit          rsp_en;
  bit          done_s;

  ifu_fetch_queue #(.PC_W(32), .INSTR_W(32), .DEPTH(4), .MAX_OTF(2)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_rtvec      (pc_rtvec),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_req_pc    (ifu_req_pc),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_ready (ifu_rsp_ready),
    .ifu_rsp_err   (ifu_rsp_err),
    .ifu_rsp_instr (ifu_rsp_instr),
    .ifu_o_valid   (ifu_o_valid),
    .ifu_o_ready   (ifu_o_ready),
    .ifu_o_ir      (ifu_o_ir),
    .ifu_o_pc      (ifu_o_pc),
    .ifu_o_buserr  (ifu_o_buserr),
    .pipe_flush_req(pipe_flush_req),
    .pipe_flush_pc (pipe_flush_pc),
    .pipe_flush_ack(pipe_flush_ack),
    .ifu_halt_req  (ifu_halt_req),
    .ifu_halt_ack  (ifu_halt_ack),
    .ifu_otf_cnt   (ifu_otf_cnt)
  );

  ifu_fetch_queue #(.PC_W(8), .INSTR_W(32), .DEPTH(4), .MAX_OTF(2)) u_dut_s (
    .clk           (clk),
    .rst_n         (rst_s_n),
    .pc_rtvec      (8'hFC),
    .ifu_req_valid (req_valid_s),
    .ifu_req_ready (1'b1),
    .ifu_req_pc    (req_pc_s),
    .ifu_rsp_valid (rsp_valid_s),
    .ifu_rsp_ready (rsp_ready_s),
    .ifu_rsp_err   (rsp_err_s),
    .ifu_rsp_instr (rsp_instr_s),
    .ifu_o_valid   (o_valid_s),
    .ifu_o_ready   (1'b1),
    .ifu_o_ir      (o_ir_s),
    .ifu_o_pc      (o_pc_s),
    .ifu_o_buserr  (o_buserr_s),
    .pipe_flush_req(1'b0),
    .pipe_flush_pc (8'h00),
    .pipe_flush_ack(flush_ack_s),
    .ifu_halt_req  (1'b0),
    .ifu_halt_ack  (halt_ack_s),
    .ifu_otf_cnt   (otf_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: score the pop, then run the bus model (1-cycle response delay, in order).
  task automatic tick();
    bit          req_fire, rsp_fire;
    logic [31:0] fire_pc, exp_ir;
    #1;
    req_fire = ifu_req_valid && ifu_req_ready;
    fire_pc  = ifu_req_pc;
    rsp_fire = ifu_rsp_valid;
    if (ifu_o_valid && ifu_o_ready) begin
      exp_ir = ~exp_pc;
      check("pop_pc", ifu_o_pc, exp_pc);
      check("pop_ir", ifu_o_ir, exp_ir);
      check("pop_err", ifu_o_buserr, 1'b0);
      exp_pc = exp_pc + 32'd4;
      n_pop++;
    end
    @(posedge clk);
    #1;
    if (rsp_fire && bus_q.size() > 0) void'(bus_q.pop_front());
    if (req_fire) begin
      bus_q.push_back(fire_pc);
      last_req_pc = fire_pc;
      n_req++;
    end
    if (rsp_en && bus_q.size() > 0) begin
      ifu_rsp_valid = 1'b1;
      ifu_rsp_instr = ~bus_q[0];
    end else begin
      ifu_rsp_valid = 1'b0;
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0; n_pop = 0; n_req = 0;
    rst_n = 1'b0; pc_rtvec = 32'h8000_0000; ifu_req_ready = 1'b1;
    ifu_rsp_valid = 1'b0; ifu_rsp_err = 1'b0; ifu_rsp_instr = '0; ifu_o_ready = 1'b1;
    pipe_flush_req = 1'b0; pipe_flush_pc = '0; ifu_halt_req = 1'b0;
    rsp_en = 1'b1; exp_pc = 32'h8000_0000; last_req_pc = '0;
    #2;
    check("rst_req_valid", ifu_req_valid, 1'b0);
    check("rst_o_valid", ifu_o_valid, 1'b0);
    check("rst_halt_ack", ifu_halt_ack, 1'b0);
    check("rst_otf", ifu_otf_cnt, 2'd0);
    check("rst_rsp_ready", ifu_rsp_ready, 1'b1);
    check("rst_flush_ack", pipe_flush_ack, 1'b1);
    check("rst_o_ir", ifu_o_ir, 32'h0);
    check("rst_o_pc", ifu_o_pc, 32'h0);
    check("rst_o_buserr", ifu_o_buserr, 1'b0);

    // Boot fetch
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1; #1;
    check("boot_c0_req", ifu_req_valid, 1'b0);
    tick();
    check("boot_c1_req", ifu_req_valid, 1'b1);
    check("boot_c1_pc", ifu_req_pc, 32'h8000_0000);
    check("boot_c1_ovalid", ifu_o_valid, 1'b0);
    tick();
    check("boot_c2_pc", ifu_req_pc, 32'h8000_0004);
    check("boot_c2_otf", ifu_otf_cnt, 2'd1);
    check("boot_c2_ovalid", ifu_o_valid, 1'b0);
    tick();
    check("boot_c3_ovalid", ifu_o_valid, 1'b1);
    check("boot_c3_opc", ifu_o_pc, 32'h8000_0000);
    check("boot_c3_req_pc", ifu_req_pc, 32'h8000_0008);
    for (int i = 0; i < 6; i++) tick();
    check("boot_pops", n_pop, 6);

    // Backpressure: queue fills, requests stop, then 4 entries drain in order
    ifu_o_ready = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("bp_req_valid", ifu_req_valid, 1'b0);
    check("bp_otf", ifu_otf_cnt, 2'd0);
    check("bp_head_pc", ifu_o_pc, exp_pc);
    ifu_o_ready = 1'b1;
    base = n_pop;
    for (int i = 0; i < 4; i++) tick();
    check("bp_drain", n_pop - base, 4);
    for (int i = 0; i < 6; i++) tick();

    // Flush with 2 in flight: both stale responses must be dropped
    rsp_en = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("fl2_otf", ifu_otf_cnt, 2'd2);
    pipe_flush_req = 1'b1; pipe_flush_pc = 32'h0000_0100; exp_pc = 32'h0000_0100; rsp_en = 1'b1;
    #1;
    check("fl2_ovalid", ifu_o_valid, 1'b0);
    check("fl2_req", ifu_req_valid, 1'b0);
    tick();
    pipe_flush_req = 1'b0;
    base = n_pop;
    for (int i = 0; i < 8; i++) tick();
    check("fl2_pops", (n_pop - base) >= 3, 1'b1);

    // Flush coincident with a response: nothing to drop afterwards
    check("flc_otf_pre", ifu_otf_cnt, 2'd1);
    pipe_flush_req = 1'b1; pipe_flush_pc = 32'h0000_0200; exp_pc = 32'h0000_0200;
    #1;
    check("flc_ovalid", ifu_o_valid, 1'b0);
    check("flc_req", ifu_req_valid, 1'b0);
    tick();
    pipe_flush_req = 1'b0;
    #1;
    check("flc_req_next", ifu_req_valid, 1'b1);
    check("flc_req_pc", ifu_req_pc, 32'h0000_0200);
    check("flc_otf", ifu_otf_cnt, 2'd0);
    tick(); tick();
    check("flc_ovalid2", ifu_o_valid, 1'b1);
    check("flc_opc", ifu_o_pc, 32'h0000_0200);
    for (int i = 0; i < 6; i++) tick();

    // Halt with 2 outstanding; queue retained; resume sequentially
    rsp_en = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("halt_otf_pre", ifu_otf_cnt, 2'd2);
    ifu_halt_req = 1'b1; ifu_o_ready = 1'b0; rsp_en = 1'b1;
    base = n_req;
    #1;
    check("halt_req_off", ifu_req_valid, 1'b0);
    tick(); tick(); tick();
    check("halt_otf0", ifu_otf_cnt, 2'd0);
    tick();
    check("halt_ack", ifu_halt_ack, 1'b1);
    check("halt_retained", ifu_o_valid, 1'b1);
    check("halt_head_pc", ifu_o_pc, exp_pc);
    tick(); tick();
    check("halt_noreq", n_req - base, 0);
    ifu_halt_req = 1'b0; ifu_o_ready = 1'b1;
    #1;
    check("halt_ack_hold", ifu_halt_ack, 1'b1);
    check("halt_req_hold", ifu_req_valid, 1'b0);
    tick();
    check("halt_ack_fall", ifu_halt_ack, 1'b0);
    check("resume_req", ifu_req_valid, 1'b1);
    check("resume_pc", ifu_req_pc, last_req_pc + 32'd4);
    for (int i = 0; i < 8; i++) tick();

    // Mid-operation reset
    rst_n = 1'b0;
    #1;
    check("mrst_req", ifu_req_valid, 1'b0);
    check("mrst_ovalid", ifu_o_valid, 1'b0);
    check("mrst_otf", ifu_otf_cnt, 2'd0);
    bus_q.delete(); ifu_rsp_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; exp_pc = 32'h8000_0000;
    tick();
    check("mrst_boot_pc", ifu_req_pc, 32'h8000_0000);
    base = n_pop;
    for (int i = 0; i < 5; i++) tick();
    check("mrst_pops", (n_pop - base) >= 2, 1'b1);

    for (int i = 0; i < 100 && !done_s; i++) @(posedge clk);
    check("small_done", done_s, 1'b1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // 8-bit PC instance: bus error on the first response, then wrap 0xFC -> 0x00
  initial begin
    bit          fire;
    logic [7:0]  fpc;
    logic [7:0]  p_pc[8];
    logic        p_err[8];
    logic [31:0] p_ir[8];
    int          np;
    done_s = 1'b0; np = 0; fire = 1'b0; fpc = '0;
    rst_s_n = 1'b0; rsp_valid_s = 1'b0; rsp_err_s = 1'b0; rsp_instr_s = '0;
    @(posedge clk); @(posedge clk); #1;
    rst_s_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #2;
      fire = req_valid_s;
      fpc  = req_pc_s;
      if (o_valid_s && np < 8) begin
        p_pc[np] = o_pc_s; p_err[np] = o_buserr_s; p_ir[np] = o_ir_s;
        np++;
      end
      @(posedge clk); #1;
      rsp_valid_s = fire;
      rsp_instr_s = {24'h0, fpc};
      rsp_err_s   = fire && (fpc == 8'hFC);
    end
    check("small_pops", np >= 3, 1'b1);
    if (np >= 3) begin
      check("small_pc0", p_pc[0], 8'hFC);
      check("small_err0", p_err[0], 1'b1);
      check("small_ir0", p_ir[0], 32'h0000_00FC);
      check("small_pc1", p_pc[1], 8'h00);
      check("small_err1", p_err[1], 1'b0);
      check("small_pc2", p_pc[2], 8'h04);
    end
    done_s = 1'b1;
  end

endmodule
